// File: rtl/ret_stack_pkg.sv
// Shared constants for the return-address stack, the PC counter and the decode unit.
// Holds the default geometry and the occupancy-derived FSM state encodings.
package ret_stack_pkg;

    localparam int RS_WIDTH = 10;
    localparam int RS_DEPTH = 8;

    localparam logic [1:0] RS_EMPTY   = 2'd0;
    localparam logic [1:0] RS_PARTIAL = 2'd1;
    localparam logic [1:0] RS_FULL    = 2'd2;

    // The stack state is a pure function of occupancy.
    function automatic logic [1:0] rs_state(input int cnt, input int dep);
        if (cnt == 0)
            return RS_EMPTY;
        else if (cnt >= dep)
            return RS_FULL;
        else
            return RS_PARTIAL;
    endfunction

endpackage

// File: rtl/ret_stack_mem.sv
// Storage for the return-address stack: depth x width registers,
// one synchronous write port and one asynchronous read port.
module ret_stack_mem
    import ret_stack_pkg::*;
#(
    parameter int width = RS_WIDTH,
    parameter int depth = RS_DEPTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(depth)-1:0] i_waddr,
    input  logic [width-1:0]         i_wdata,
    input  logic [$clog2(depth)-1:0] i_raddr,
    output logic [width-1:0]         o_rdata
);

    logic [width-1:0] r_mem [depth];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ret_stack.sv
// Return-address stack driving jmp/jmpLoc into the PC counter.
// Build option RET_STACK_WRAP_EN: push on a full stack overwrites the oldest entry.
module ret_stack
    import ret_stack_pkg::*;
#(
    parameter int width = RS_WIDTH,
    parameter int depth = RS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [width-1:0]           pushData,
    input  logic                       pop,
    output logic                       jmp,
    output logic [width-1:0]           jmpLoc,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       err
);

    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(depth);

    logic [AW-1:0]    r_tos;
    logic [CW-1:0]    r_count;
    logic             r_jmp;
    logic [width-1:0] r_jmpLoc;
    logic             r_empty;
    logic             r_full;
    logic             r_err;

    logic [1:0]       w_state;
    logic [width-1:0] w_top;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_tos_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_jmp_nxt;
    logic [width-1:0] w_jmpLoc_nxt;
    logic             w_err_nxt;

    assign w_state = rs_state(int'(r_count), depth);

    ret_stack_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we && !rst),
        .i_waddr (w_waddr),
        .i_wdata (pushData),
        .i_raddr (r_tos),
        .o_rdata (w_top)
    );

    always_comb begin
        w_we         = 1'b0;
        w_waddr      = r_tos + 1'b1;
        w_tos_nxt    = r_tos;
        w_cnt_nxt    = r_count;
        w_jmp_nxt    = 1'b0;
        w_jmpLoc_nxt = r_jmpLoc;
        w_err_nxt    = r_err;

        if (push && pop) begin
            w_jmp_nxt = 1'b1;
            if (w_state == RS_EMPTY) begin
                // Bypass: the call and its return cancel without touching storage.
                w_jmpLoc_nxt = pushData;
            end else begin
                w_jmpLoc_nxt = w_top;
                w_we         = 1'b1;
                w_waddr      = r_tos;
            end
        end else if (push) begin
            if (w_state != RS_FULL) begin
                w_we      = 1'b1;
                w_tos_nxt = r_tos + 1'b1;
                w_cnt_nxt = r_count + 1'b1;
            end else begin
`ifdef RET_STACK_WRAP_EN
                w_we      = 1'b1;
                w_tos_nxt = r_tos + 1'b1;
`else
                w_err_nxt = 1'b1;
`endif
            end
        end else if (pop) begin
            if (w_state != RS_EMPTY) begin
                w_jmp_nxt    = 1'b1;
                w_jmpLoc_nxt = w_top;
                w_tos_nxt    = r_tos - 1'b1;
                w_cnt_nxt    = r_count - 1'b1;
            end else begin
                w_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tos    <= '1;
            r_count  <= '0;
            r_jmp    <= 1'b0;
            r_jmpLoc <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_tos    <= w_tos_nxt;
            r_count  <= w_cnt_nxt;
            r_jmp    <= w_jmp_nxt;
            r_jmpLoc <= w_jmpLoc_nxt;
            r_empty  <= (w_cnt_nxt == '0);
            r_full   <= (w_cnt_nxt == CNT_FULL);
            r_err    <= w_err_nxt;
        end
    end

    assign jmp    = r_jmp;
    assign jmpLoc = r_jmpLoc;
    assign count  = r_count;
    assign empty  = r_empty;
    assign full   = r_full;
    assign err    = r_err;

endmodule

// File: tb/tb_ret_stack.sv
// Bench for ret_stack: directed scenarios plus random traffic checked against a queue-based model.
module tb_ret_stack;

    localparam int W = 10;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         push = 1'b0;
    logic [W-1:0] pushData = '0;
    logic         pop = 1'b0;
    logic         jmp;
    logic [W-1:0] jmpLoc;
    logic [3:0]   count;
    logic         empty;
    logic         full;
    logic         err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the stack as a queue, newest entry at the back.
    logic [W-1:0] m_q[$];
    logic         m_jmp = 1'b0;
    logic [W-1:0] m_loc = '0;
    logic         m_err = 1'b0;

    ret_stack #(.width(W), .depth(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushData (pushData),
        .pop      (pop),
        .jmp      (jmp),
        .jmpLoc   (jmpLoc),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic ps, input logic [W-1:0] d, input logic pp, input logic rs);
        if (rs) begin
            m_q.delete();
            m_jmp = 1'b0;
            m_loc = '0;
            m_err = 1'b0;
        end else begin
            m_jmp = 1'b0;
            if (ps && pp) begin
                m_jmp = 1'b1;
                if (m_q.size() == 0) begin
                    m_loc = d;
                end else begin
                    m_loc = m_q[m_q.size()-1];
                    m_q[m_q.size()-1] = d;
                end
            end else if (ps) begin
                if (m_q.size() < D) begin
                    m_q.push_back(d);
                end else begin
`ifdef RET_STACK_WRAP_EN
                    void'(m_q.pop_front());
                    m_q.push_back(d);
`else
                    m_err = 1'b1;
`endif
                end
            end else if (pp) begin
                if (m_q.size() > 0) begin
                    m_jmp = 1'b1;
                    m_loc = m_q.pop_back();
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model, check every output just after the edge.
    task automatic step(input logic ps, input logic [W-1:0] d, input logic pp, input logic rs);
        push = ps; pushData = d; pop = pp; rst = rs;
        @(posedge clk);
        model(ps, d, pp, rs);
        #1;
        chk("m_jmp",    32'(jmp),    32'(m_jmp));
        chk("m_jmpLoc", 32'(jmpLoc), 32'(m_loc));
        chk("m_count",  32'(count),  m_q.size());
        chk("m_empty",  32'(empty),  32'(m_q.size() == 0));
        chk("m_full",   32'(full),   32'(m_q.size() == D));
        chk("m_err",    32'(err),    32'(m_err));
        push = 1'b0; pop = 1'b0; rst = 1'b0;
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 1);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_jmpLoc", 32'(jmpLoc), 0);

        // Three calls, three returns back to back
        step(1, 10'h010, 0, 0);
        step(1, 10'h020, 0, 0);
        step(1, 10'h030, 0, 0);
        step(0, 0, 1, 0); chk("pop1", 32'(jmpLoc), 32'h030); chk("pop1_jmp", 32'(jmp), 1);
        step(0, 0, 1, 0); chk("pop2", 32'(jmpLoc), 32'h020); chk("pop2_jmp", 32'(jmp), 1);
        step(0, 0, 1, 0); chk("pop3", 32'(jmpLoc), 32'h010); chk("pop3_jmp", 32'(jmp), 1);
        chk("pop3_empty", 32'(empty), 1);
        step(0, 0, 0, 0); chk("idle_jmp", 32'(jmp), 0); chk("idle_loc", 32'(jmpLoc), 32'h010);

        // Underflow is sticky until reset
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        chk("uf_jmp", 32'(jmp), 0); chk("uf_loc", 32'(jmpLoc), 0); chk("uf_err", 32'(err), 1);
        step(1, 10'h044, 0, 0);
        step(0, 0, 1, 0);
        chk("uf_sticky", 32'(err), 1);
        step(0, 0, 0, 1);
        chk("uf_clear", 32'(err), 0);

        // Replace top with same-cycle push and pop
        step(1, 10'h005, 0, 0);
        step(1, 10'h3FF, 1, 0);
        chk("rep_loc", 32'(jmpLoc), 32'h005); chk("rep_jmp", 32'(jmp), 1); chk("rep_cnt", 32'(count), 1);
        step(0, 0, 1, 0);
        chk("rep_pop", 32'(jmpLoc), 32'h3FF);

        // Bypass on empty
        step(0, 0, 0, 1);
        step(1, 10'h123, 1, 0);
        chk("byp_loc", 32'(jmpLoc), 32'h123); chk("byp_jmp", 32'(jmp), 1);
        chk("byp_cnt", 32'(count), 0); chk("byp_err", 32'(err), 0);

        // Nine pushes into an eight-deep stack
        step(0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) step(1, W'(i), 0, 0);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_cnt", 32'(count), 8);
`ifdef RET_STACK_WRAP_EN
        chk("ovf_err", 32'(err), 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            chk("ovf_pop", 32'(jmpLoc), 32'(9 - i));
        end
`else
        chk("ovf_err", 32'(err), 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            chk("ovf_pop", 32'(jmpLoc), 32'(8 - i));
        end
`endif
        chk("ovf_empty", 32'(empty), 1);

        // Push and pop together on full is a replace
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, W'(10'h100 + i), 0, 0);
        step(1, 10'h2AA, 1, 0);
        chk("fullrep_loc", 32'(jmpLoc), 32'h107); chk("fullrep_err", 32'(err), 0);
        step(0, 0, 1, 0);
        chk("fullrep_pop", 32'(jmpLoc), 32'h2AA);

        // Reset with pop suppresses the jump
        step(0, 0, 0, 1);
        step(1, 10'h011, 0, 0);
        step(1, 10'h022, 0, 0);
        step(0, 0, 1, 1);
        chk("rstpop_jmp", 32'(jmp), 0); chk("rstpop_cnt", 32'(count), 0);
        chk("rstpop_empty", 32'(empty), 1); chk("rstpop_loc", 32'(jmpLoc), 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic ps, pp, rs;
            logic [W-1:0] d;
            ps = ($urandom_range(0, 99) < 55);
            pp = ($urandom_range(0, 99) < 45);
            rs = ($urandom_range(0, 99) < 2);
            d  = W'($urandom);
            step(ps, d, pp, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
